// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the sequential floating-point multiplier.
// Field-width helpers take plain int widths so they work for any EXP_W/MAN_W.
package fp_mul_pkg;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

  localparam int MAX_W = 64;

  function automatic int bias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  function automatic logic [MAX_W-1:0] exp_all_ones(input int expW);
    return (MAX_W'(1) << expW) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] canonical_nan(input int expW, input int manW);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < expW; i++) v[manW+i] = 1'b1;
    v[manW-1] = 1'b1;
    return v;
  endfunction

  function automatic logic is_nan(input logic [MAX_W-1:0] expF, input logic [MAX_W-1:0] manF,
                                  input int expW);
    return (expF == exp_all_ones(expW)) && (manF != '0);
  endfunction

  function automatic logic is_inf(input logic [MAX_W-1:0] expF, input logic [MAX_W-1:0] manF,
                                  input int expW);
    return (expF == exp_all_ones(expW)) && (manF == '0);
  endfunction

  // Denormals share the zero exponent and are flushed to zero.
  function automatic logic is_zero(input logic [MAX_W-1:0] expF);
    return expF == '0;
  endfunction

endpackage

// File: rtl/seq_mantissa_multiplier.sv
// Unsigned iterative shift-add multiplier: one partial product per cycle.
// done is high during the Nth cycle after start; prod is final the cycle after.
module seq_mantissa_multiplier #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{N{1'b0}}, x};
      mplier_d = y;
      count_d  = CW'(N);
    end else if (count_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign done = (count_q == CW'(1));
  assign prod = acc_q;

endmodule

// File: rtl/seq_float_multiplier.sv
// Handshaked floating-point multiplier: specials resolve in one cycle, normal
// operands go through the iterative mantissa multiplier, then RNE and range checks.
module seq_float_multiplier
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     exception,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S    = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_LIMIT = EW'((1 << EXP_W) - 1);
  localparam logic [MAX_W-1:0]     NAN_FULL  = canonical_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]         NAN_WORD  = NAN_FULL[W-1:0];

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W-1:0]   expA_q, expA_d, expB_q, expB_d;
  logic [W-1:0]       result_q, result_d;
  logic               exception_q, exception_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic [EXP_W-1:0]   aExp, bExp;
  logic [MAN_W-1:0]   aMan, bMan;
  logic               aNan, bNan, aInf, bInf, aZero, bZero;
  logic               inSign, accept, special, start, mulDone;
  logic [2*N-1:0]     prod;

  logic               prodTop;
  logic [2*N-2:0]     normProd;
  logic [MAN_W-1:0]   manTrunc, manRounded;
  logic               guardBit, stickyBit, roundUp, roundCarry;
  logic signed [EW-1:0] expFinal;

  assign aExp   = a[W-2:MAN_W];
  assign bExp   = b[W-2:MAN_W];
  assign aMan   = a[MAN_W-1:0];
  assign bMan   = b[MAN_W-1:0];
  assign aNan   = is_nan(MAX_W'(aExp), MAX_W'(aMan), EXP_W);
  assign bNan   = is_nan(MAX_W'(bExp), MAX_W'(bMan), EXP_W);
  assign aInf   = is_inf(MAX_W'(aExp), MAX_W'(aMan), EXP_W);
  assign bInf   = is_inf(MAX_W'(bExp), MAX_W'(bMan), EXP_W);
  assign aZero  = is_zero(MAX_W'(aExp));
  assign bZero  = is_zero(MAX_W'(bExp));
  assign inSign = a[W-1] ^ b[W-1];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign special   = aNan || bNan || aInf || bInf || aZero || bZero;
  assign start     = accept && !special;

  seq_mantissa_multiplier #(.N(N)) u_mant (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     ({1'b1, aMan}),
    .y     ({1'b1, bMan}),
    .done  (mulDone),
    .prod  (prod)
  );

  // A rounding carry-out wraps the mantissa to zero and bumps the exponent.
  assign prodTop   = prod[2*N-1];
  assign normProd  = prodTop ? prod[2*N-2:0] : {prod[2*N-3:0], 1'b0};
  assign manTrunc  = normProd[2*MAN_W:MAN_W+1];
  assign guardBit  = normProd[MAN_W];
  assign stickyBit = |normProd[MAN_W-1:0];
  assign roundUp   = guardBit && (stickyBit || manTrunc[0]);
  assign {roundCarry, manRounded} = {1'b0, manTrunc} + (MAN_W+1)'(roundUp);
  assign expFinal  = {2'b00, expA_q} + {2'b00, expB_q} - BIAS_S
                   + EW'(prodTop) + EW'(roundCarry);

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    expA_d      = expA_q;
    expB_d      = expB_q;
    result_d    = result_q;
    exception_d = exception_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = inSign;
          expA_d = aExp;
          expB_d = bExp;
          if (special) begin
            state_d     = DONE;
            exception_d = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) begin
              result_d    = NAN_WORD;
              exception_d = 1'b1;
            end else if (aInf || bInf) begin
              result_d = {inSign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
              result_d = {inSign, {(W-1){1'b0}}};
            end
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: if (mulDone) state_d = NORM;
      NORM: begin
        state_d     = DONE;
        exception_d = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (expFinal >= EXP_LIMIT) begin
          result_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          overflow_d = 1'b1;
        end else if (expFinal[EW-1] || expFinal == '0) begin
          result_d    = {sign_q, {(W-1){1'b0}}};
          underflow_d = 1'b1;
        end else begin
          result_d = {sign_q, expFinal[EXP_W-1:0], manRounded};
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      expA_q      <= '0;
      expB_q      <= '0;
      result_q    <= '0;
      exception_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      expA_q      <= expA_d;
      expB_q      <= expB_d;
      result_q    <= result_d;
      exception_q <= exception_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign result    = result_q;
  assign exception = exception_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
